// File: rtl/operand_issue_if.sv
// Handshake and issue bus between the operand feeder, its upstream source and the
// evaluation stage. master = upstream/downstream environment, slave = operand_issue_stage.
interface operand_issue_if #(
    parameter int unsigned CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data1;
    logic [7:0]       in_data2;
    logic             in_kernel;
    logic             stall;
    logic [7:0]       issue_data1;
    logic [7:0]       issue_data2;
    logic             kernel_enable;
    logic             issue_valid;
    logic             result_valid;
    logic             idle;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, in_data1, in_data2, in_kernel, stall,
        input  in_ready, issue_data1, issue_data2, kernel_enable, issue_valid,
        input  result_valid, idle, count
    );

    modport slave (
        input  in_valid, in_data1, in_data2, in_kernel, stall,
        output in_ready, issue_data1, issue_data2, kernel_enable, issue_valid,
        output result_valid, idle, count
    );
endinterface

// File: rtl/operand_issue_stage.sv
// Buffers {kernel, d1, d2} operand sets in a FIFO and issues one per cycle to the evaluation
// stage. Build option OPERAND_HOLD_EN: issue operands hold their last value on idle cycles.
module operand_issue_stage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input logic            clk,
    input logic            rst,
    operand_issue_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StStall, StDrain} state_e;

    logic [16:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    state_e           state_q;
    state_e           state_d;
    logic             push;
    logic             pop;
    logic [7:0]       data1_q;
    logic [7:0]       data2_q;
    logic             kernel_q;
    logic             issue_valid_q;
    logic             result_valid_q;

    // No full-bypass: a pop in the same cycle does not open in_ready.
    assign bus.in_ready = (count_q < CNT_W'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (count_q != '0) && !bus.stall;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage is not reset; the gate keeps reset-time pushes out of the array.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q] <= {bus.in_kernel, bus.in_data1, bus.in_data2};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            data1_q        <= '0;
            data2_q        <= '0;
            kernel_q       <= 1'b0;
            issue_valid_q  <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            count_q        <= count_d;
            result_valid_q <= issue_valid_q;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q                     <= rd_ptr_q + PTR_W'(1);
                {kernel_q, data1_q, data2_q} <= mem[rd_ptr_q];
                issue_valid_q                <= 1'b1;
            end else begin
                issue_valid_q <= 1'b0;
                kernel_q      <= 1'b0;
`ifdef OPERAND_HOLD_EN
                data1_q <= data1_q;
                data2_q <= data2_q;
`else
                data1_q <= '0;
                data2_q <= '0;
`endif
            end
        end
    end

    // Next state is judged on post-update occupancy and in-flight flags.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (count_d != '0) begin
                    state_d = bus.stall ? StStall : StIssue;
                end
            end
            StIssue, StStall: begin
                if (count_d == '0) begin
                    state_d = StDrain;
                end else begin
                    state_d = bus.stall ? StStall : StIssue;
                end
            end
            StDrain: begin
                if (count_d != '0) begin
                    state_d = bus.stall ? StStall : StIssue;
                end else if (!pop && !issue_valid_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.issue_data1   = data1_q;
    assign bus.issue_data2   = data2_q;
    assign bus.kernel_enable = kernel_q;
    assign bus.issue_valid   = issue_valid_q;
    assign bus.result_valid  = result_valid_q;
    assign bus.idle          = (state_q == StIdle);
    assign bus.count         = count_q;
endmodule

// File: tb/tb_operand_issue_stage.sv
// Self-checking bench for operand_issue_stage: directed scenarios then random traffic,
// all checked against a queue-based model of the issue stage.
module tb_operand_issue_stage;
    localparam int unsigned DEPTH = 4;
`ifdef OPERAND_HOLD_EN
    localparam logic [7:0] HOLD_D1 = 8'hA5;
    localparam logic [7:0] HOLD_D2 = 8'h5A;
`else
    localparam logic [7:0] HOLD_D1 = 8'h00;
    localparam logic [7:0] HOLD_D2 = 8'h00;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    operand_issue_if #(.CNT_W(3)) bus ();

    operand_issue_stage #(
        .DEPTH(DEPTH),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model: buffered entries plus what the issue register and result strobe should show.
    logic [16:0] m_q[$];
    logic        exp_iv = 1'b0;
    logic        exp_rv = 1'b0;
    logic        exp_ke = 1'b0;
    logic [7:0]  exp_d1 = 8'h00;
    logic [7:0]  exp_d2 = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_outputs(input string ph);
        chk({ph, ".issue_valid"}, 32'(bus.issue_valid), 32'(exp_iv));
        chk({ph, ".issue_data1"}, 32'(bus.issue_data1), 32'(exp_d1));
        chk({ph, ".issue_data2"}, 32'(bus.issue_data2), 32'(exp_d2));
        chk({ph, ".kernel_enable"}, 32'(bus.kernel_enable), 32'(exp_ke));
        chk({ph, ".result_valid"}, 32'(bus.result_valid), 32'(exp_rv));
        chk({ph, ".count"}, 32'(bus.count), 32'(m_q.size()));
        // Idle means nothing buffered and nothing issued or awaiting its result.
        chk({ph, ".idle"}, 32'(bus.idle),
            32'((m_q.size() == 0) && !exp_iv && !exp_rv));
    endtask

    task automatic step(input bit v, input logic [7:0] d1, input logic [7:0] d2,
                        input bit k, input bit st, input string ph);
        bit          do_push;
        bit          do_pop;
        logic [16:0] head;
        bus.in_valid  = v;
        bus.in_data1  = d1;
        bus.in_data2  = d2;
        bus.in_kernel = k;
        bus.stall     = st;
        #1;
        chk({ph, ".in_ready"}, 32'(bus.in_ready), 32'(m_q.size() < DEPTH));
        do_pop  = (m_q.size() != 0) && !st;
        do_push = v && (m_q.size() < DEPTH);
        exp_rv  = exp_iv;
        if (do_pop) begin
            head = m_q.pop_front();
            {exp_ke, exp_d1, exp_d2} = head;
            exp_iv = 1'b1;
        end else begin
            exp_iv = 1'b0;
            exp_ke = 1'b0;
`ifndef OPERAND_HOLD_EN
            exp_d1 = 8'h00;
            exp_d2 = 8'h00;
`endif
        end
        if (do_push) m_q.push_back({k, d1, d2});
        @(posedge clk);
        #1;
        chk_outputs(ph);
    endtask

    task automatic quiet(input string ph);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, ph);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data1  = 8'h00;
        bus.in_data2  = 8'h00;
        bus.in_kernel = 1'b0;
        bus.stall     = 1'b0;

        #1 rst = 1'b1;
        #1 chk_outputs("reset");

        // Offers during reset must not land in the FIFO.
        bus.in_valid = 1'b1;
        bus.in_data1 = 8'h77;
        @(posedge clk);
        #1;
        chk("rst_push_ignored.count", 32'(bus.count), 32'd0);
        bus.in_valid = 1'b0;
        rst = 1'b0;

        // Single op, kernel on: issue one edge after the push, result one edge later.
        step(1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, "t1_push");
        chk("t1_push.issue_valid_low", 32'(bus.issue_valid), 32'd0);
        quiet("t1_issue");
        chk("t1_issue.kernel", 32'(bus.kernel_enable), 32'd1);
        chk("t1_issue.d2", 32'(bus.issue_data2), 32'hFF);
        quiet("t1_result");
        chk("t1_result.rv", 32'(bus.result_valid), 32'd1);
        quiet("t1_done");

        // Single op, kernel off.
        step(1'b1, 8'h03, 8'h0F, 1'b0, 1'b0, "t2_push");
        quiet("t2_issue");
        quiet("t2_result");
        quiet("t2_rv_drop");
        chk("t2.idle_back", 32'(bus.idle), 32'd1);

        // Fill under stall: fifth offer is held until space opens.
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 8'(i), 8'(8'h10 + i), 1'b0, 1'b1, "t3_fill");
        end
        chk("t3.full_count", 32'(bus.count), 32'd4);
        chk("t3.full_ready", 32'(bus.in_ready), 32'd0);
        step(1'b1, 8'h05, 8'h15, 1'b0, 1'b0, "t3_release_full");
        step(1'b1, 8'h05, 8'h15, 1'b0, 1'b0, "t3_release_accept");
        for (int i = 0; i < 6; i++) quiet("t3_drain");

        // Stall raised after the first issue.
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 8'(i), 8'(8'h20 + i), 1'b1, 1'b1, "t4_load");
        end
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "t4_first");
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "t4_stalled");
        chk("t4.count_held", 32'(bus.count), 32'd2);
        for (int i = 0; i < 4; i++) quiet("t4_resume");

        // Asynchronous reset between edges with work buffered and in flight.
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'(8'h30 + i), 8'(8'h40 + i), 1'b1, 1'b1, "t5_load");
        end
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "t5_inflight");
        #2 rst = 1'b1;
        #1;
        m_q.delete();
        exp_iv = 1'b0;
        exp_rv = 1'b0;
        exp_ke = 1'b0;
        exp_d1 = 8'h00;
        exp_d2 = 8'h00;
        chk_outputs("t5_async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) quiet("t5_after");

        // Operand hold build option.
        step(1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0, "t6_push");
        for (int i = 0; i < 4; i++) quiet("t6_idle");
        chk("t6.hold_d1", 32'(bus.issue_data1), 32'(HOLD_D1));
        chk("t6.hold_d2", 32'(bus.issue_data2), 32'(HOLD_D2));
        chk("t6.hold_ke", 32'(bus.kernel_enable), 32'd0);

        // Random traffic with bursty stalls.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
                 $urandom_range(0, 9) < 4, "rand");
        end
        for (int i = 0; i < 8; i++) quiet("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/operand_issue_stage.md
Name: operand_issue_stage

Overview:
- Upstream feeder for the ROM/evaluation stage.
- Accepts operand pairs and a per-operation kernel flag through a valid/ready handshake, and buffers them in a small FIFO.
- Issues at most one registered operand set per cycle on the evaluation stage's `data_in1`/`data_in2`/`kernel_enable` inputs.
- Drives a `result_valid` strobe aligned to that stage's 1-cycle result register, plus an `idle` flag usable as a clock-gating enable.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CNT_W, 3, width of `count`; must hold values 0..DEPTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream offers an operand set
- in_ready  output  1  stage can accept this cycle
- in_data1  input  8  operand 1; low nibble is the ROM address downstream
- in_data2  input  8  operand 2; inverted downstream
- in_kernel  input  1  per-operation kernel select
- stall  input  1  downstream hold request; blocks issue
- issue_data1  output  8  to `data_in1`
- issue_data2  output  8  to `data_in2`
- kernel_enable  output  1  to `kernel_enable`
- issue_valid  output  1  issue outputs carry a live operand set this cycle
- result_valid  output  1  evaluation stage's `result` is valid this cycle
- idle  output  1  no buffered or in-flight work
- count  output  CNT_W  current FIFO occupancy

Behaviour:
Reset:
- rst asynchronously clears read/write pointers, `count`, FSM (to IDLE), `issue_*`, `kernel_enable`, `issue_valid` and `result_valid` to 0, and sets `idle` to 1.
- FIFO array contents are not reset.
- A reset mid-operation discards all buffered entries and all in-flight flags; nothing is issued after release until a new push.
- Pushes are ignored while rst is high.

Handshake and FIFO:
- Entry = {kernel, d1, d2}, 17 bits.
- in_ready = (count < DEPTH), combinational.
- Push when in_valid && in_ready.
- Pop when count != 0 && !stall.
- When full, in_ready = 0 even if a pop occurs in the same cycle (no full-bypass).
- Push into an empty FIFO is not issued in the same cycle (no empty-bypass).
- A simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
- Pointers wrap modulo DEPTH.

Issue path:
- On a pop edge, `issue_data1`/`issue_data2`/`kernel_enable` load the head entry and `issue_valid` goes to 1.
- On an edge without a pop, `issue_valid` goes to 0 and `kernel_enable` goes to 0.
- Latency: an entry pushed into an empty FIFO at edge N appears on issue outputs after edge N+1. Its evaluation result is valid after edge N+2, coincident with `result_valid`.
- `result_valid` = `issue_valid` delayed one cycle.
- Order is strictly FIFO.
- When stall rises, issue stops at the next edge. Entries are preserved, and issue resumes the edge after stall falls.

FSM (registered), transitions at each edge after push/pop update:
- IDLE: count == 0 and no issue_valid/result_valid pending. `idle` = 1.
  - Goes to ISSUE if a pop is possible.
  - Goes to STALL if count > 0 and stall is high.
- ISSUE: popping this cycle.
  - Goes to STALL if stall is high and count > 0.
  - Goes to DRAIN if count becomes 0.
- STALL: stall is high with entries buffered.
  - Goes to ISSUE when stall falls.
- DRAIN: waits for `result_valid` of the last entry.
  - Goes to IDLE when it clears, or to ISSUE if new data is present.
- `idle` = (state == IDLE), registered.

Optional Feature:
- Macro: OPERAND_HOLD_EN.
- Defined: on non-issue cycles, `issue_data1`/`issue_data2` hold their last issued values to minimise toggling into the evaluation stage. `kernel_enable` is still forced to 0.
- Undefined: on non-issue cycles, `issue_data1`/`issue_data2` are driven to 0x00 and `kernel_enable` to 0.

Test Plan:
- Single operation, kernel on: push d1=0x00, d2=0xFF, k=1 into an empty FIFO -> `issue_valid`=1 one cycle later with 0x00/0xFF/ke=1; `result_valid` the following cycle; evaluation result = 57 (0x39).
- Single operation, kernel off: push d1=0x03, d2=0x0F, k=0 -> kernel_enable=0; result = 0xF0 + 0x03 = 0xF3; `result_valid` pulses exactly 1 cycle; `idle` returns to 1 two cycles later.
- Fill under stall: hold stall=1 and offer 5 sets (d1=0x01..0x05) -> 4 accepted, count=4, in_ready=0, fifth held. Release stall -> 4 consecutive issue cycles in order 0x01..0x04, then 0x05 accepted and issued.
- Stall mid-stream: 3 entries queued, stall raised after the first issue -> `issue_valid`=0 while stalled, count stays 2; on release, 0x02 then 0x03 are issued back-to-back.
- Reset mid-operation: 3 entries buffered plus one in flight, assert rst asynchronously between edges -> all outputs go to 0 and idle=1 immediately, count=0; after release, no issue occurs without a new push.
- OPERAND_HOLD_EN: issue 0xA5/0x5A then go idle -> with the macro, `issue_data` holds 0xA5/0x5A; without it, 0x00/0x00. kernel_enable=0 in both builds.
